// File: rtl/zl_conv_enc_sched_pkg.sv
// Shared definitions for the convolutional-encoder frame sequencer.
// Holds the FSM state encoding, default sync byte values and a flush-length helper.
// No logic; imported by the sequencer top.
package zl_conv_enc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DFLT     = 8'h47;
  localparam logic [7:0] SYNC_INV_BYTE_DFLT = 8'hB8;

  // Zero bytes needed to push K-1 memory bits out of a constraint-length-K encoder.
  function automatic int flush_bytes_for_k(input int k);
    return (k - 1 + 7) / 8;
  endfunction

endpackage

// File: rtl/zl_conv_enc_sched_if.sv
// Byte stream link with req/ack handshake; a byte moves in any cycle with req && ack.
// Latency: none (wires only). Backpressure: receiver holds ack low to stall.
// Ports: data[7:0], req (master drives), ack (slave drives).
interface zl_conv_enc_sched_if;
  logic [7:0] data;
  logic       req;
  logic       ack;

  modport master (output data, output req, input ack);
  modport slave  (input data, input req, output ack);
endinterface

// File: rtl/zl_byte_counter.sv
// Transfer counter with synchronous clear, increment-on-transfer and terminal-count flag.
// Latency: count updates one cycle after clr/inc; at_last is combinational from the count.
// Backpressure: none; the owner only pulses inc on real transfers.
module zl_byte_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last_val,
  output logic         at_last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_last = (cnt_q == last_val);

endmodule

// File: rtl/zl_conv_enc_sched.sv
// Frame sequencer for the rate-1/2 encoder: sync byte, PKT_LEN payload bytes, FLUSH_BYTES zeros.
// Latency: IDLE->SYNC one cycle after enable; payload is a zero-latency pass-through.
// Backpressure: enc.ack stalls every state; up.ack only fires with enc.ack in PAYLOAD.
// Ports: clk, rst_n (async active-low), enable, up (slave byte link), enc (master byte link),
//        frame_start (sync byte accepted), busy (not IDLE).
// Option: ZL_CONV_ENC_SCHED_SYNC_INV_EN sends SYNC_INV_BYTE as every 8th sync (frame_cnt==0).
module zl_conv_enc_sched
  import zl_conv_enc_sched_pkg::*;
#(
  parameter int         PKT_LEN       = 187,
  parameter int         FLUSH_BYTES   = 1,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DFLT,
  parameter logic [7:0] SYNC_INV_BYTE = SYNC_INV_BYTE_DFLT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  zl_conv_enc_sched_if.slave          up,
  zl_conv_enc_sched_if.master         enc,
  output logic                        frame_start,
  output logic                        busy
);

  localparam int             PW         = $clog2(PKT_LEN + 1);
  localparam logic [PW-1:0]  PAY_LAST   = PW'(PKT_LEN - 1);
  localparam logic [3:0]     FLUSH_LAST = (FLUSH_BYTES > 0) ? 4'(FLUSH_BYTES - 1) : 4'd0;

  state_e     state_q, state_d;
  state_e     eof_state;
  logic       sync_xfer, pay_xfer, flush_xfer;
  logic       pay_last, flush_last;
  logic       inv_now;
  logic [7:0] sync_byte;

  assign sync_xfer  = (state_q == ST_SYNC)    && enc.ack;
  assign pay_xfer   = (state_q == ST_PAYLOAD) && up.req && enc.ack;
  assign flush_xfer = (state_q == ST_FLUSH)   && enc.ack;

  zl_byte_counter #(.W(PW)) u_pay_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sync_xfer),
    .inc      (pay_xfer),
    .last_val (PAY_LAST),
    .at_last  (pay_last)
  );

  zl_byte_counter #(.W(4)) u_flush_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pay_xfer && pay_last),
    .inc      (flush_xfer),
    .last_val (FLUSH_LAST),
    .at_last  (flush_last)
  );

`ifdef ZL_CONV_ENC_SCHED_SYNC_INV_EN
  // Counts sync transfers; frame 0 of every group of 8 carries the inverted sync.
  logic [2:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (sync_xfer) frame_cnt_d = frame_cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= 3'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign inv_now = (frame_cnt_q == 3'd0);
`else
  assign inv_now = 1'b0;
`endif

  assign sync_byte = inv_now ? SYNC_INV_BYTE : SYNC_BYTE;

  // enable is only looked at in IDLE and at end-of-frame, so a frame always completes.
  assign eof_state = enable ? ST_SYNC : ST_IDLE;

  always_comb begin
    state_d  = state_q;
    enc.req  = 1'b0;
    enc.data = 8'h00;
    up.ack   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        enc.req  = 1'b1;
        enc.data = sync_byte;
        if (enc.ack) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        enc.req  = up.req;
        enc.data = up.data;
        up.ack   = up.req && enc.ack;
        if (pay_xfer && pay_last) state_d = (FLUSH_BYTES == 0) ? eof_state : ST_FLUSH;
      end
      ST_FLUSH: begin
        enc.req = 1'b1;
        if (enc.ack && flush_last) state_d = eof_state;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign frame_start = sync_xfer;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zl_conv_enc_sched.sv
// Bench for zl_conv_enc_sched with PKT_LEN=4, FLUSH_BYTES=1.
// A frame-position model predicts every output each cycle; directed phases pin the model.
module tb_zl_conv_enc_sched;

  localparam int PKT_LEN     = 4;
  localparam int FLUSH_BYTES = 1;
  localparam int FRAME       = 1 + PKT_LEN + FLUSH_BYTES;
`ifdef ZL_CONV_ENC_SCHED_SYNC_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  localparam logic [7:0] FIRST_SYNC = INV_EN ? 8'hB8 : 8'h47;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic frame_start, busy;

  zl_conv_enc_sched_if up_if ();
  zl_conv_enc_sched_if enc_if ();

  zl_conv_enc_sched #(
    .PKT_LEN       (PKT_LEN),
    .FLUSH_BYTES   (FLUSH_BYTES),
    .SYNC_BYTE     (8'h47),
    .SYNC_INV_BYTE (8'hB8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .up          (up_if),
    .enc         (enc_if),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: whether a frame is in progress, position in frame, frames since reset,
  // next payload byte the encoder must see.
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  int         m_frames = 0;
  logic [7:0] m_pay    = 8'h01;

  logic [7:0] log_q[$];
  int         xfer_cnt  = 0;
  int         upack_cnt = 0;
  int         fs_cnt    = 0;
  bit         s_up_ack  = 1'b0;

  bit         e_req, e_pay, e_upack, e_fs;
  logic [7:0] e_dat;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_enc_req", 32'(enc_if.req), 32'd0);
      chk("rst_up_ack", 32'(up_if.ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_enc_data", 32'(enc_if.data), 32'd0);
      m_active = 1'b0;
      m_pos    = 0;
      m_frames = 0;
      s_up_ack = 1'b0;
    end else begin
      e_pay   = m_active && (m_pos >= 1) && (m_pos <= PKT_LEN);
      e_req   = m_active && (e_pay ? up_if.req : 1'b1);
      e_dat   = (m_pos == 0) ? ((INV_EN && (m_frames % 8 == 0)) ? 8'hB8 : 8'h47)
              : e_pay ? m_pay : 8'h00;
      e_upack = e_pay && up_if.req && enc_if.ack;
      e_fs    = m_active && (m_pos == 0) && enc_if.ack;
      chk("busy", 32'(busy), 32'(m_active));
      chk("enc_req", 32'(enc_if.req), 32'(e_req));
      chk("up_ack", 32'(up_if.ack), 32'(e_upack));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      if (e_req) chk("enc_data", 32'(enc_if.data), 32'(e_dat));
      s_up_ack = up_if.ack;
      if (enc_if.req && enc_if.ack) begin
        log_q.push_back(enc_if.data);
        xfer_cnt++;
      end
      if (up_if.ack) upack_cnt++;
      if (frame_start) fs_cnt++;
      if (!m_active) begin
        m_active = enable;
        m_pos    = 0;
      end else if (e_req && enc_if.ack) begin
        if (m_pos == 0) m_frames++;
        if (e_pay) m_pay++;
        m_pos++;
        if (m_pos == FRAME) begin
          m_pos    = 0;
          m_active = enable;
        end
      end
    end
  end

  // Stimulus: upstream source presents an incrementing byte, advancing only when acked.
  int         cyc      = 0;
  int         ack_mode = 0;  // 0 always, 1 every 8th cycle, 2 random
  int         req_mode = 0;  // 0 always, 1 random, 2 held low
  logic [7:0] src_val  = 8'h01;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (s_up_ack) src_val++;
    case (ack_mode)
      0:       enc_if.ack = 1'b1;
      1:       enc_if.ack = (cyc % 8 == 0);
      default: enc_if.ack = ($urandom_range(0, 3) != 0);
    endcase
    case (req_mode)
      0:       up_if.req = 1'b1;
      1:       up_if.req = ($urandom_range(0, 2) != 0);
      default: up_if.req = 1'b0;
    endcase
    up_if.data = src_val;
  endtask

  task automatic wait_pos(input int p, input string nm);
    int i = 0;
    while (!(m_active && m_pos == p) && i < 60) begin
      step();
      i++;
    end
    chk(nm, 32'(m_active && m_pos == p), 32'd1);
  endtask

  logic [7:0] t1_exp [6];
  int x0, u0;

  initial begin
    up_if.data = 8'h01;
    up_if.req  = 1'b0;
    enc_if.ack = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Single frame from reset with source and encoder always ready.
    enable = 1'b1;
    chk("t1_busy_before", 32'(busy), 32'd0);
    step();
    chk("t1_busy_after", 32'(busy), 32'd1);
    for (int i = 0; i < 30 && xfer_cnt < 6; i++) step();
    chk("t1_xfers", 32'(xfer_cnt), 32'd6);
    t1_exp = '{FIRST_SYNC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    for (int i = 0; i < 6; i++)
      if (log_q.size() > i) chk("t1_byte", 32'(log_q[i]), 32'(t1_exp[i]));
    chk("t1_frame_start", 32'(fs_cnt), 32'd1);

    // Three back-to-back frames: contiguous transfers.
    x0 = xfer_cnt; u0 = upack_cnt;
    repeat (18) step();
    chk("t2_xfers", 32'(xfer_cnt - x0), 32'd18);
    chk("t2_upacks", 32'(upack_cnt - u0), 32'd12);

    // Upstream stalls for 5 cycles mid-payload.
    wait_pos(2, "t3_reach_payload");
    x0 = xfer_cnt;
    req_mode = 2;
    up_if.req = 1'b0;
    repeat (4) step();
    req_mode = 0;
    step();
    chk("t3_stall_xfers", 32'(xfer_cnt - x0), 32'd0);
    repeat (20) step();

    // Slow encoder: one ack every 8 cycles.
    ack_mode = 1;
    repeat (8) step();
    x0 = xfer_cnt; u0 = upack_cnt;
    repeat (48) step();
    chk("t4_xfers", 32'(xfer_cnt - x0), 32'd6);
    chk("t4_upacks", 32'(upack_cnt - u0), 32'd4);

    // enable dropped after the second payload byte: frame still completes.
    ack_mode = 0;
    wait_pos(3, "t5_reach_byte3");
    enable = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i < 20 && busy; i++) step();
    chk("t5_tail_xfers", 32'(xfer_cnt - x0), 32'd3);
    repeat (4) step();
    chk("t5_idle_xfers", 32'(xfer_cnt - x0), 32'd3);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // Reset mid-payload, then nine frames of sync bytes.
    enable = 1'b1;
    wait_pos(2, "t6_reach_payload");
    rst_n = 1'b0;
    #1;
    chk("t6_rst_enc_req", 32'(enc_if.req), 32'd0);
    chk("t6_rst_up_ack", 32'(up_if.ack), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    x0 = xfer_cnt;
    for (int i = 0; i < 200 && xfer_cnt < x0 + 9 * FRAME; i++) step();
    chk("t6_xfers", 32'(xfer_cnt - x0), 32'(9 * FRAME));
    for (int f = 0; f < 9; f++)
      if (log_q.size() > x0 + f * FRAME)
        chk("t6_sync_seq", 32'(log_q[x0 + f * FRAME]),
            32'((INV_EN && (f % 8 == 0)) ? 8'hB8 : 8'h47));

    // Random traffic, enable toggles and occasional resets.
    ack_mode = 2;
    req_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    enable = 1'b0;
    ack_mode = 0;
    repeat (20) step();
    chk("end_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
